// File: rtl/instr_cache_set_fill.sv
// One set of the L1 instruction cache: E ways with true-LRU ages, a combinational
// hit path and a beat-wise refill from L2 with backpressure.
//
// state | meaning
// IDLE  | lookups served; a miss on an active set starts a refill
// FILL  | RepReady high; beats of the victim block are written as RepValid arrives
module instr_cache_set_fill #(
  parameter int B          = 64,
  parameter int NumTagBits = 20,
  parameter int E          = 4,
  parameter int FW         = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ActiveSet,
  input  logic [$clog2(B)-1:0]    Block,
  input  logic [NumTagBits-1:0]   Tag,
  input  logic                    RepValid,
  input  logic [FW-1:0]           RepWord,
  input  logic                    Flush,
  output logic [31:0]             Data,
  output logic                    CacheMiss,
  output logic                    RepReady,
  output logic                    FillDone
);

  localparam int b     = $clog2(B);
  localparam int Beats = B * 8 / FW;
  localparam int AW    = $clog2(E);
  localparam int CW    = (Beats > 1) ? $clog2(Beats) : 1;

  typedef enum logic [0:0] {IDLE, FILL} stateT;

  stateT                  state, nextState;
  logic [NumTagBits-1:0]  tagArr [E];
  logic [B*8-1:0]         dataArr [E];
  logic [E-1:0]           valid;
  logic [AW-1:0]          age [E];
  logic [NumTagBits-1:0]  fillTag;
  logic [AW-1:0]          victim, victimReg, hitWay;
  logic [CW-1:0]          beatCnt;
  logic [E-1:0]           hitVec;
  logic                   hit, accept, lastBeat, startFill;
  logic                   unusedOffset;

  assign unusedOffset = ^Block[1:0];

  always_comb begin
    hitVec = '0;
    hitWay = '0;
    victim = '0;
    for (int i = 0; i < E; i++)
      hitVec[i] = valid[i] && (tagArr[i] == Tag);
    for (int i = E - 1; i >= 0; i--)
      if (hitVec[i]) hitWay = AW'(i);
    // Oldest valid way by default; any invalid way (lowest index) takes precedence.
    for (int i = 0; i < E; i++)
      if (age[i] == AW'(E - 1)) victim = AW'(i);
    for (int i = E - 1; i >= 0; i--)
      if (!valid[i]) victim = AW'(i);
  end

  assign hit       = ActiveSet && (|hitVec) && (state == IDLE);
  assign CacheMiss = ActiveSet && !hit;
  assign RepReady  = (state == FILL);
  assign accept    = RepReady && RepValid;
  assign lastBeat  = accept && (beatCnt == CW'(Beats - 1));
  assign startFill = (state == IDLE) && ActiveSet && CacheMiss && !Flush;
  assign Data      = dataArr[hitWay][32 * int'(Block[b-1:2]) +: 32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (Flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (startFill) nextState = FILL;
        FILL:    if (lastBeat)  nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid     <= '0;
      beatCnt   <= '0;
      FillDone  <= 1'b0;
      fillTag   <= '0;
      victimReg <= '0;
      for (int i = 0; i < E; i++) age[i] <= '0;
    end else if (Flush) begin
      valid    <= '0;
      beatCnt  <= '0;
      FillDone <= 1'b0;
      for (int i = 0; i < E; i++) age[i] <= '0;
    end else begin
      FillDone <= lastBeat;
      if (startFill) begin
        fillTag   <= Tag;
        victimReg <= victim;
        beatCnt   <= '0;
      end
      if (accept) beatCnt <= beatCnt + CW'(1);
      if (hit) begin
        for (int i = 0; i < E; i++)
          if (valid[i] && (age[i] < age[hitWay])) age[i] <= age[i] + AW'(1);
        age[hitWay] <= '0;
      end
      // An invalid victim has no meaningful age, so every valid way gets older.
      if (lastBeat) begin
        for (int i = 0; i < E; i++)
          if (valid[i] && (!valid[victimReg] || (age[i] < age[victimReg])))
            age[i] <= age[i] + AW'(1);
        age[victimReg]   <= '0;
        valid[victimReg] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !Flush) dataArr[victimReg][int'(beatCnt) * FW +: FW] <= RepWord;
    if (lastBeat && !Flush) tagArr[victimReg] <= fillTag;
  end

endmodule
